// File: rtl/fe_window_gen.sv
// 5x5 "same"-padded sliding-window generator for the feature-extraction stage.
// Walks a (IMG_H+2)x(IMG_W+2) grid, inserting zeros off-image, and emits one window per image pixel.
module fe_window_gen #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int PIX_W       = 8,
  parameter int FILTER_SIZE = 5
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       start,
  input  logic [PIX_W-1:0]                           pix_in,
  input  logic                                       pix_valid,
  output logic                                       pix_ready,
  output logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0]   win_out,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic                                       win_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int K  = FILTER_SIZE;
  localparam int LW = IMG_W + 2;
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                     state_q;
  logic [RW-1:0]              r_q;
  logic [CW-1:0]              c_q;
  logic                       drain_q;
  logic [K*K*PIX_W-1:0]       win_out_q;
  logic                       win_valid_q;
  logic                       win_last_q;
  logic                       busy_q;
  logic                       done_q;

  // Line buffers hold rows r-1 .. r-(K-1) at each padded column; never cleared.
  logic [PIX_W-1:0]           lb_q  [K-1][LW];
  // Last K-1 columns of the raw (unmasked) window.
  logic [PIX_W-1:0]           win_q [K][K-1];

  logic                       inb;
  logic                       emit;
  logic                       last_pos;
  logic                       step_en;
  logic [PIX_W-1:0]           samp;
  logic [PIX_W-1:0]           col_d [K];
  logic [PIX_W-1:0]           win_d [K][K];
  logic [K*K*PIX_W-1:0]       win_nx;

  assign inb      = (r_q < RW'(IMG_H)) && (c_q < CW'(IMG_W));
  assign emit     = (r_q >= RW'(2)) && (c_q >= CW'(2));
  assign last_pos = (r_q == RW'(IMG_H + 1)) && (c_q == CW'(IMG_W + 1));
  assign samp     = inb ? pix_in : '0;

  // A pending window only blocks steps that would overwrite it.
  assign step_en  = (state_q == SCAN) && !drain_q
                 && (!inb || pix_valid)
                 && (!emit || !win_valid_q || win_ready);

  assign pix_ready = step_en && inb;
  assign win_out   = win_out_q;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    for (int i = 0; i < K - 1; i++) begin
      col_d[i] = lb_q[K-2-i][c_q];
    end
    col_d[K-1] = samp;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        win_d[i][j] = win_q[i][j];
      end
      win_d[i][K-1] = col_d[i];
    end
  end

  // Taps above row 0 or left of column 0 are forced to zero, which hides
  // stale line-buffer rows and the previous row's right-hand columns.
  always_comb begin
    win_nx = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if ((int'(r_q) + i >= K - 1) && (int'(c_q) + j >= K - 1)) begin
          win_nx[PIX_W*(K*i+j) +: PIX_W] = win_d[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (step_en) begin
      lb_q[0][c_q] <= samp;
      for (int k = 1; k < K - 1; k++) begin
        lb_q[k][c_q] <= lb_q[k-1][c_q];
      end
      for (int i = 0; i < K; i++) begin
        for (int m = 0; m < K - 1; m++) begin
          win_q[i][m] <= win_d[i][m+1];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      r_q         <= '0;
      c_q         <= '0;
      drain_q     <= 1'b0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            r_q     <= '0;
            c_q     <= '0;
            drain_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SCAN: begin
          if (win_valid_q && win_ready) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
          end
          if (step_en) begin
            if (emit) begin
              win_out_q   <= win_nx;
              win_valid_q <= 1'b1;
              win_last_q  <= last_pos;
            end
            if (c_q == CW'(IMG_W + 1)) begin
              c_q <= '0;
              if (last_pos) drain_q <= 1'b1;
              else          r_q     <= r_q + RW'(1);
            end else begin
              c_q <= c_q + CW'(1);
            end
          end
          // After the final step the grid is drained; finish on the last handshake.
          if (win_valid_q && win_ready && win_last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fe_window_gen.sv
// Directed bench for fe_window_gen: a 4x4 instance for hand-checked windows and stalls,
// a default 32x32 instance for random-gap streaming and mid-frame reset.
module tb_fe_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sel, start, pv, wr;
  logic [7:0]   pix;
  logic         pr4, wv4, wl4, busy4, done4;
  logic         pr32, wv32, wl32, busy32, done32;
  logic [199:0] win4, win32;
  logic         pr, wv, wl, busy, done;
  logic [199:0] win;
  logic [7:0]   img [0:1023];
  int           nchk, nerr;

  fe_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8), .FILTER_SIZE(5)) u_dut4 (
    .clk_in(clk), .rst_in(rst), .start(start && !sel), .pix_in(pix), .pix_valid(pv),
    .pix_ready(pr4), .win_out(win4), .win_valid(wv4), .win_ready(wr), .win_last(wl4),
    .busy(busy4), .done(done4));

  fe_window_gen u_dut32 (
    .clk_in(clk), .rst_in(rst), .start(start && sel), .pix_in(pix), .pix_valid(pv),
    .pix_ready(pr32), .win_out(win32), .win_valid(wv32), .win_ready(wr), .win_last(wl32),
    .busy(busy32), .done(done32));

  assign pr   = sel ? pr32   : pr4;
  assign wv   = sel ? wv32   : wv4;
  assign wl   = sel ? wl32   : wl4;
  assign busy = sel ? busy32 : busy4;
  assign done = sel ? done32 : done4;
  assign win  = sel ? win32  : win4;

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: zero-padded 5x5 neighbourhood of image pixel (y,x).
  function automatic logic [199:0] exp_win(input int y, input int x, input int w, input int h);
    logic [199:0] v;
    int yy, xx;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        yy = y - 2 + i;
        xx = x - 2 + j;
        if (yy >= 0 && yy < h && xx >= 0 && xx < w) v[8*(5*i+j) +: 8] = img[yy*w+xx];
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] tap(input logic [199:0] wv_i, input int k);
    return wv_i[8*k +: 8];
  endfunction

  task automatic run_frame(input int w, input int h, input int pvp, input int wrp,
                           input int stall_win, input int mid_start, input int abort_pix,
                           output logic [199:0] fw, output logic [199:0] lw, output int nbusy);
    int npix, nwin, ndone, nlast, cyc, stall_cnt, hs_cyc;
    bit stl;
    npix = 0; nwin = 0; ndone = 0; nlast = 0; cyc = 0; stall_cnt = 0; hs_cyc = -10;
    nbusy = 0; fw = '0; lw = '0;
    @(negedge clk); start = 1'b1; pv = 1'b0; wr = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("busy_rise", busy, 1);
    while (cyc < 20000) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        chk("done_busy_low", busy, 0);
        chk("done_timing", cyc, hs_cyc + 1);
        break;
      end
      if (abort_pix > 0 && npix >= abort_pix) break;
      stl   = (stall_win >= 0 && nwin == stall_win && wv && stall_cnt < 10);
      pv    = ($urandom_range(99) < pvp);
      pix   = (npix < w*h) ? img[npix] : 8'h00;
      wr    = stl ? 1'b0 : ($urandom_range(99) < wrp);
      start = (mid_start > 0 && cyc == mid_start);
      #1;
      if (stl) begin
        chk("stall_pr", pr, 0);
        chk("stall_win", win, exp_win(nwin / w, nwin % w, w, h));
        stall_cnt++;
      end
      if (pv && pr) npix++;
      if (wv && wr) begin
        if (nwin == 0) fw = win;
        if (nwin == w*h-1) lw = win;
        chk($sformatf("win%0d", nwin), win, exp_win(nwin / w, nwin % w, w, h));
        chk($sformatf("last%0d", nwin), wl, (nwin == w*h-1));
        if (wl) nlast++;
        hs_cyc = cyc;
        nwin++;
      end
      @(negedge clk);
      cyc++;
    end
    pv = 1'b0; wr = 1'b0; start = 1'b0;
    if (abort_pix == 0) begin
      repeat (5) begin
        @(negedge clk);
        if (done) ndone++;
      end
      chk("done_once", ndone, 1);
      chk("npix", npix, w*h);
      chk("nwin", nwin, w*h);
      chk("nlast", nlast, 1);
      if (stall_win >= 0) chk("stall_cycles", stall_cnt, 10);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [199:0] fw, lw;
    int nbusy;
    nchk = 0; nerr = 0;
    rst = 1'b1; sel = 1'b0; start = 1'b0; pv = 1'b0; wr = 1'b0; pix = '0;
    repeat (3) @(negedge clk);
    chk("rst_pr", pr, 0);
    chk("rst_wv", wv, 0);
    chk("rst_wl", wl, 0);
    chk("rst_win", win, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    sel = 1'b1;
    #1;
    chk("rst32_wv", wv, 0);
    chk("rst32_win", win, 0);
    sel = 1'b0;
    rst = 1'b0;

    // 4x4 streaming, p(r,c)=4r+c+1
    for (int i = 0; i < 16; i++) img[i] = 8'(i + 1);
    run_frame(4, 4, 100, 100, -1, 0, 0, fw, lw, nbusy);
    chk("f1_busy_cycles", nbusy, 37);
    for (int k = 0; k < 12; k++) chk($sformatf("first_tap%0d", k), tap(fw, k), 0);
    chk("first_tap12", tap(fw, 12), 1);
    chk("first_tap13", tap(fw, 13), 2);
    chk("first_tap14", tap(fw, 14), 3);
    chk("first_tap17", tap(fw, 17), 5);
    chk("first_tap18", tap(fw, 18), 6);
    chk("first_tap19", tap(fw, 19), 7);
    chk("first_tap22", tap(fw, 22), 9);
    chk("first_tap23", tap(fw, 23), 10);
    chk("first_tap24", tap(fw, 24), 11);
    chk("last_tap0", tap(lw, 0), 6);
    chk("last_tap1", tap(lw, 1), 7);
    chk("last_tap2", tap(lw, 2), 8);
    chk("last_tap3", tap(lw, 3), 0);
    chk("last_tap12", tap(lw, 12), 16);
    chk("last_tap24", tap(lw, 24), 0);

    // 4x4 with a 10-cycle downstream stall on window 5 and a start pulse mid-scan
    run_frame(4, 4, 100, 100, 5, 10, 0, fw, lw, nbusy);

    // 32x32 random pixels with random valid/ready gaps
    sel = 1'b1;
    for (int i = 0; i < 1024; i++) img[i] = 8'($urandom_range(255));
    run_frame(32, 32, 70, 70, -1, 0, 0, fw, lw, nbusy);

    // abandon a frame after 50 pixels, then a fresh all-0xFF frame
    run_frame(32, 32, 100, 100, -1, 0, 50, fw, lw, nbusy);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wv", wv, 0);
    chk("abort_busy", busy, 0);
    chk("abort_win", win, 0);
    @(negedge clk);
    chk("abort_done_after", done, 0);
    for (int i = 0; i < 1024; i++) img[i] = 8'hFF;
    run_frame(32, 32, 100, 100, -1, 0, 0, fw, lw, nbusy);
    for (int k = 0; k < 12; k++) chk($sformatf("ff_tap%0d", k), tap(fw, k), 0);
    chk("ff_tap12", tap(fw, 12), 8'hFF);
    chk("ff_tap15", tap(fw, 15), 0);
    chk("ff_tap24", tap(fw, 24), 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fe_window_gen.md
# fe_window_gen

Upstream neighbour of the feature-extraction convolution stage. Accepts a single-channel low-resolution image as a raster-order pixel stream and emits one 5x5 zero-padded ("same" padding, 2 pixels each side) window per input pixel, also in raster order. The feature-extraction stage consumes each window and applies its 25-tap kernels, so the output contains exactly IMG_H*IMG_W windows per frame.

## Interface
- IMG_W, 32, image width in pixels (>= 3)
- IMG_H, 32, image height in pixels (>= 3)
- PIX_W, 8, pixel width, unsigned
- FILTER_SIZE, 5, window dimension; only 5 is supported
- clk_in  in  1  single clock; all logic rising-edge
- rst_in  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- pix_in  in  PIX_W  input pixel
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_out  out  25*PIX_W  window; tap k = 5*i+j (row i, col j, tap 0 top-left, tap 12 centre) at bits [PIX_W*k +: PIX_W]
- win_valid  out  1  win_out valid
- win_ready  in  1  downstream accepts win_out
- win_last  out  1  qualifies the final window of the frame
- busy  out  1  high from accepted start until frame end
- done  out  1  one-cycle pulse after the last window handshake

## Operation
- States: IDLE, SCAN. IDLE -> SCAN on start. SCAN -> IDLE when the window at scan position (IMG_H+1, IMG_W+1) is accepted. start is ignored in SCAN.
- SCAN walks a padded grid r = 0..IMG_H+1, c = 0..IMG_W+1, raster order, one position per step. Counters reset to (0,0) on entering SCAN.
- In-bounds position (r<IMG_H and c<IMG_W): the step consumes one pixel. Out-of-bounds position: the step inserts zero and consumes nothing.
- Each step shifts the sample into a 5x5 window register, fed by 4 line buffers of depth IMG_W+2 PIX_W-bit entries.
- Positions with r>=2 and c>=2 emit the window centred on image pixel (y,x) = (r-2, c-2).
- Emitted tap (i,j) maps to image pixel (y-2+i, x-2+j). A tap is forced to zero if that row or column is < 0, so stale line-buffer or previous-row content never appears. Taps with row >= IMG_H or col >= IMG_W are already zero from insertion.
- Step enable: state == SCAN AND (out-of-bounds OR pix_valid) AND (non-emitting OR !win_valid OR win_ready).
- pix_ready = step enable AND in-bounds. pix_ready never depends combinationally on win_valid alone, only through the stall term above.
- win_last = win_valid for the window at (IMG_H-1, IMG_W-1).

## Timing
- Reset: state IDLE, counters 0, pix_ready=0, win_valid=0, win_last=0, win_out=0, busy=0, done=0. Line buffers are not cleared. Reset mid-frame abandons the frame with no done pulse.
- busy is asserted the cycle after start is sampled in IDLE.
- A window is registered on the clock edge of its emitting step. win_valid rises the next cycle.
- win_out and win_last hold stable while win_valid=1 and win_ready=0. When stalled, no pixel is consumed and no counter advances.
- Throughput: 1 step per cycle with pix_valid and win_ready held high. A frame takes (IMG_H+2)*(IMG_W+2) steps plus 1 cycle.
- A handshake and a new window in the same cycle is allowed: win_valid stays high with new data.
- done pulses 1 cycle after the win_last handshake. busy drops in the same cycle as done.
- start coincident with rst_in: reset wins.

## Test plan
- IMG_W=IMG_H=4, pixel p(r,c)=4r+c+1, streaming. First window: taps 0-11 = 0,0,0,0,0,0,0,0,0,0,0,0 except tap 12=1, 13=2, 14=3, 17=5, 18=6, 19=7, 22=9, 23=10, 24=11.
- Same frame, last window (3,3): tap 0=6, 1=7, 2=8, 3=0, 12=16, 24=0, win_last=1. done pulses next cycle and busy falls.
- Default 32x32 with random pix_valid and win_ready gaps: exactly 1024 pixels consumed and 1024 windows out, in raster order. Each window matches the reference model. win_last appears only on the 1024th window.
- Hold win_ready=0 for 10 cycles with a window pending: win_out is constant and pix_ready=0 throughout. Releasing win_ready resumes with no lost or duplicated window.
- Assert rst_in mid-frame (after 50 pixels), then start a new frame p(r,c)=0xFF. The first window has no nonzero taps outside the zero-forced pattern (tap 12=0xFF, taps 0-11=0), proving no stale data.
- Pulse start during SCAN: frame unaffected, window count is still IMG_H*IMG_W, and there is a single done pulse.
